shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 103 ++++++++++
 tb/tb_shift_add_multiplier.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential WIDTH x WIDTH unsigned shift-and-add multiplier.
// Optional macro MULT_EARLY_EXIT_EN ends the RUN phase as soon as the remaining multiplier bits are zero.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic               start_ok;
    logic               run;
    logic               last_iter;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] carry;
    logic [2*WIDTH-1:0] acc_add;

    // One ripple-carry adder shared by every iteration; the top carry is never needed.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < 2*WIDTH; i++) begin : g_fa
        assign sum[i] = acc_q[i] ^ mcand_q[i] ^ carry[i];
        if (i < 2*WIDTH - 1) begin : g_c
            assign carry[i+1] = (acc_q[i] & mcand_q[i]) | (carry[i] & (acc_q[i] ^ mcand_q[i]));
        end
    end

    assign start_ok = (state_q == IDLE) && start;
    assign run      = (state_q == RUN);

`ifdef MULT_EARLY_EXIT_EN
    assign last_iter = (cnt_q == LAST) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_q == LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: launch on start, iterate, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_iter ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next values: load operands on accept, shift/accumulate while running.
    always_comb begin
        acc_add  = mplier_q[0] ? sum : acc_q;
        mcand_d  = start_ok ? {{WIDTH{1'b0}}, a} : run ? mcand_q << 1 : mcand_q;
        mplier_d = start_ok ? b : run ? mplier_q >> 1 : mplier_q;
        acc_d    = start_ok ? '0 : run ? acc_add : acc_q;
        cnt_d    = start_ok ? '0 : run ? cnt_q + CW'(1) : cnt_q;
        p_d      = (run && last_iter) ? acc_add : p_q;
    end

    // Datapath registers; p captures the final sum on the RUN -> DONE transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign p = p_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized self-checking bench against an arithmetic reference model.
module tb_shift_add_multiplier;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .p(p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected number of RUN cycles for a given multiplier operand.
    function automatic int run_cycles(input logic [W-1:0] bv);
`ifdef MULT_EARLY_EXIT_EN
        int r = 1;
        for (int i = 0; i < W; i++) if (bv[i]) r = i + 1;
        return r;
`else
        return W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiplication with exact cycle-by-cycle handshake checks; noisy drives junk during RUN/DONE.
    task automatic mul(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noisy);
        int r = run_cycles(bv);
        int e = int'(av) * int'(bv);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        for (int k = 1; k <= r; k++) begin
            check("busy_run", 32'(busy), 1);
            check("done_run", 32'(done), 0);
            start = noisy ? 1'($urandom) : 1'b0;
            if (noisy) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
        end
        check("done_pulse", 32'(done), 1);
        check("busy_done", 32'(busy), 0);
        check("p_result", 32'(p), e);
        start = noisy ? 1'($urandom) : 1'b0;
        tick();
        start = 1'b0;
        check("done_clear", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check("p_hold", 32'(p), e);
    endtask

    initial begin
        int t;
        int pulses;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_p", 32'(p), 0);
        rst = 1'b0;
        tick();

        mul(4'd15, 4'd15, 1'b0);
        mul(4'd0, 4'd9, 1'b0);
        mul(4'd7, 4'd0, 1'b0);
        mul(4'd3, 4'd2, 1'b0);
        mul(4'd5, 4'd6, 1'b1);

        // Reset two edges into a 9*9 operation: abort, clear p, no done pulse afterwards.
        a = 4'd9;
        b = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_p", 32'(p), 0);
        pulses = 0;
        repeat (W + 3) begin
            tick();
            pulses += int'(done) + int'(busy);
        end
        check("abort_quiet", 32'(pulses), 0);
        mul(4'd2, 4'd3, 1'b0);

        // start held high: back-to-back operations spaced by run cycles + 2.
        a = 4'd10;
        b = 4'd11;
        start = 1'b1;
        t = 0;
        while (!done && t < 40) begin
            tick();
            t++;
        end
        check("held_lat1", 32'(t), run_cycles(4'd11) + 1);
        check("held_p1", 32'(p), 110);
        a = 4'd4;
        b = 4'd12;
        tick();
        t = 1;
        while (!done && t < 40) begin
            tick();
            t++;
        end
        start = 1'b0;
        check("held_gap", 32'(t), run_cycles(4'd12) + 2);
        check("held_p2", 32'(p), 48);
        tick();
        tick();
        check("held_idle", 32'(busy), 0);

        for (int i = 0; i < 256; i++) mul(W'(i >> 4), W'(i), 1'($urandom));
        repeat (40) mul(W'($urandom), W'($urandom), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
